// File: rtl/sample_fifo_if.sv
// Write/read handshake and status bundle for sample_fifo.
// The master modport belongs to the producer/consumer side; the slave modport belongs to the FIFO.
interface sample_fifo_if #(
    parameter int BITS = 16,
    parameter int SIZE = 128
);
    localparam int MAX_BITS = $clog2(SIZE);

    logic                wr_en;
    logic [BITS-1:0]     wr_data;
    logic                rd_en;
    logic                clr_err;
    logic [BITS-1:0]     rd_data;
    logic                rd_valid;
    logic                fifo_empty;
    logic                fifo_full;
    logic                almost_empty;
    logic                almost_full;
    logic [MAX_BITS:0]   fill;
    logic                overflow;
    logic                underflow;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, fifo_empty, fifo_full,
               almost_empty, almost_full, fill, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, fifo_empty, fifo_full,
               almost_empty, almost_full, fill, overflow, underflow
    );
endinterface

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with fill count, almost-full/empty flags and sticky overflow/underflow.
// Define SAMPLE_FIFO_FWFT_EN for first-word-fall-through reads; the default is a registered read.
module sample_fifo #(
    parameter int BITS     = 16,
    parameter int SIZE     = 128,
    parameter int AF_LEVEL = SIZE - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    sample_fifo_if.slave bus
);
    localparam int MAX_BITS = $clog2(SIZE);

    typedef logic [MAX_BITS:0] cnt_t;
    typedef logic [BITS-1:0]   word_t;

    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam cnt_t CNT_FULL = cnt_t'(SIZE);
    localparam cnt_t CNT_AF   = cnt_t'(AF_LEVEL);
    localparam cnt_t CNT_AE   = cnt_t'(AE_LEVEL);

    word_t mem_q [SIZE];

    cnt_t  wr_ptr_q, wr_ptr_d;
    cnt_t  rd_ptr_q, rd_ptr_d;
    cnt_t  fill_q, fill_d;
    logic  empty_q, empty_d;
    logic  full_q, full_d;
    logic  ae_q, ae_d;
    logic  af_q, af_d;
    logic  ovf_q, ovf_d;
    logic  unf_q, unf_d;
    word_t rd_data_q, rd_data_d;
    logic  rd_valid_q, rd_valid_d;
    logic  rd_ok, wr_ok;

    // NOTE: every variable gets a default at the top of an always_comb so no path can infer a latch.
    always_comb begin
        rd_ok    = bus.rd_en && (fill_q != '0);
        // A write into a full FIFO is legal only when a read frees the head slot on the same edge.
        wr_ok    = bus.wr_en && ((fill_q != CNT_FULL) || rd_ok);
        wr_ptr_d = wr_ok ? wr_ptr_q + CNT_ONE : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + CNT_ONE : rd_ptr_q;

        fill_d = fill_q;
        if (wr_ok && !rd_ok) begin
            fill_d = fill_q + CNT_ONE;
        end else if (rd_ok && !wr_ok) begin
            fill_d = fill_q - CNT_ONE;
        end

        empty_d = (fill_d == '0);
        full_d  = (fill_d == CNT_FULL);
        ae_d    = (fill_d <= CNT_AE);
        af_d    = (fill_d >= CNT_AF);

        ovf_d = ovf_q;
        if (bus.wr_en && !wr_ok) begin
            ovf_d = 1'b1;
        end else if (bus.clr_err) begin
            ovf_d = 1'b0;
        end

        unf_d = unf_q;
        if (bus.rd_en && !rd_ok) begin
            unf_d = 1'b1;
        end else if (bus.clr_err) begin
            unf_d = 1'b0;
        end
    end

`ifdef SAMPLE_FIFO_FWFT_EN
    // Present the new head once it was stored before this edge; the shown word stays counted in fill.
    always_comb begin
        rd_valid_d = rd_ok ? (fill_q > CNT_ONE) : (fill_q != '0);
        rd_data_d  = rd_valid_d ? mem_q[rd_ptr_d[MAX_BITS-1:0]] : rd_data_q;
    end
`else
    always_comb begin
        rd_valid_d = rd_ok;
        rd_data_d  = rd_ok ? mem_q[rd_ptr_q[MAX_BITS-1:0]] : rd_data_q;
    end
`endif

    // NOTE: the sample memory has no reset; stale contents are never visible because the pointers are reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q[MAX_BITS-1:0]] <= bus.wr_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            ae_q       <= 1'b1;
            af_q       <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            ae_q       <= ae_d;
            af_q       <= af_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.fifo_empty   = empty_q;
    assign bus.fifo_full    = full_q;
    assign bus.almost_empty = ae_q;
    assign bus.almost_full  = af_q;
    assign bus.fill         = fill_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sample_fifo.sv
// Self-checking bench for sample_fifo: queue scoreboard, a vector table and hand-written corner sequences.
module tb_sample_fifo;
    localparam int BITS = 16;
    localparam int SIZE = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [BITS-1:0] sb[$];
    logic [BITS-1:0] m_rd_data = '0;
    bit              m_ovf = 1'b0;
    bit              m_unf = 1'b0;

    typedef struct {
        bit              wr;
        logic [BITS-1:0] d;
        bit              rd;
        bit              clr;
        int              fill;
        bit              ovf;
        bit              unf;
    } vec_t;

    vec_t vecs[8];

    sample_fifo_if #(.BITS(BITS), .SIZE(SIZE)) bus ();

    sample_fifo #(.BITS(BITS), .SIZE(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, " fill"},      bus.fill,         0);
        check({tag, " empty"},     bus.fifo_empty,   1);
        check({tag, " ae"},        bus.almost_empty, 1);
        check({tag, " full"},      bus.fifo_full,    0);
        check({tag, " af"},        bus.almost_full,  0);
        check({tag, " overflow"},  bus.overflow,     0);
        check({tag, " underflow"}, bus.underflow,    0);
        check({tag, " rd_data"},   bus.rd_data,      0);
        check({tag, " rd_valid"},  bus.rd_valid,     0);
    endtask

    task automatic model_reset();
        sb.delete();
        m_rd_data = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock of stimulus; the reference model predicts, then DUT outputs are compared #1 after the edge.
    task automatic cycle(input bit wr, input logic [BITS-1:0] d, input bit rd, input bit clr);
        bit rd_ok;
        bit wr_ok;
        int n;
        bus.wr_en   = wr;
        bus.wr_data = d;
        bus.rd_en   = rd;
        bus.clr_err = clr;
        rd_ok = rd && (sb.size() != 0);
        wr_ok = wr && ((sb.size() != SIZE) || rd_ok);
        if (rd_ok) m_rd_data = sb.pop_front();
        if (wr_ok) sb.push_back(d);
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (wr && !wr_ok) m_ovf = 1'b1;
        if (rd && !rd_ok) m_unf = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        n = sb.size();
`ifndef SAMPLE_FIFO_FWFT_EN
        check("rd_valid", bus.rd_valid, rd_ok);
        check("rd_data",  bus.rd_data,  m_rd_data);
`endif
        check("fill",      bus.fill,         n);
        check("empty",     bus.fifo_empty,   n == 0);
        check("full",      bus.fifo_full,    n == SIZE);
        check("ae",        bus.almost_empty, n <= 4);
        check("af",        bus.almost_full,  n >= SIZE - 4);
        check("overflow",  bus.overflow,     m_ovf);
        check("underflow", bus.underflow,    m_unf);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;

        // {wr, data, rd, clr, fill, overflow, underflow}
        vecs[0] = '{1'b1, 16'h1111, 1'b1, 1'b0, 1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 16'h2222, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 16'h3333, 1'b1, 1'b0, 1, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #2;
        reset_checks("por");
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].wr, vecs[i].d, vecs[i].rd, vecs[i].clr);
            check("vec fill",      bus.fill,      vecs[i].fill);
            check("vec overflow",  bus.overflow,  vecs[i].ovf);
            check("vec underflow", bus.underflow, vecs[i].unf);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < SIZE; i++) begin
            cycle(1'b1, BITS'(i), 1'b0, 1'b0);
        end
        check("fill at full", bus.fill, SIZE);
        check("full flag", bus.fifo_full, 1);
        cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
        check("extra write overflow", bus.overflow, 1);
        check("extra write fill", bus.fill, SIZE);

        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, BITS'(SIZE + i), 1'b1, 1'b0);
        end
        check("full r+w no overflow", bus.overflow, 0);
        check("full r+w fill", bus.fill, SIZE);

        for (int i = 0; i < SIZE; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        check("drained empty", bus.fifo_empty, 1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("extra read underflow", bus.underflow, 1);
        check("extra read rd_valid", bus.rd_valid, 0);
        check("extra read fill", bus.fill, 0);

        for (int i = 0; i < 60; i++) begin
            cycle(1'b1, BITS'(16'h4000 + i), 1'b0, 1'b0);
        end
        #3 rst_n = 1'b0;
        #2;
        reset_checks("async");
        @(posedge clk);
        #2;
        reset_checks("held");
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, BITS'(16'h5A00 + i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
`ifndef SAMPLE_FIFO_FWFT_EN
            check("post-reset data", bus.rd_data, 16'h5A00 + i);
`endif
        end

`ifdef SAMPLE_FIFO_FWFT_EN
        cycle(1'b1, 16'hA5A5, 1'b0, 1'b0);
        check("fwft before present valid", bus.rd_valid, 0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("fwft present valid", bus.rd_valid, 1);
        check("fwft present data", bus.rd_data, 16'hA5A5);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("fwft ack empty", bus.fifo_empty, 1);
        check("fwft ack valid", bus.rd_valid, 0);
        check("fwft hold data", bus.rd_data, 16'hA5A5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
